acc_multiplier: RTL and testbench

Sequential 16×16 unsigned shift-add multiplier, the execution unit behind the controller's MULT_1 / MULT_WAIT states. The datapath drives ACC onto `a` and MDR onto `b`. The controller pulses `start` in MULT_1 and spins in MULT_WAIT until `done`. It then muxes `product` into ACC_next. Only one operation is in flight at a time, and results are held stable until the next accepted start.

---
 rtl/acc_multiplier.sv | 140 ++++++++++++++
 tb/tb_acc_multiplier.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/acc_multiplier.sv
// -----------------------------------------------------------------------------
// acc_multiplier
//
// Sequential 16x16 unsigned shift-add multiplier. It is the execution unit
// behind the controller's MULT_1 / MULT_WAIT states. ACC drives `a`, MDR
// drives `b`, and the low half of the result (`product`) is written back
// into ACC.
//
// One multiplier bit is processed per clock. The result registers are
// separate from the working registers, so `product`, `prod_hi` and `ovf`
// stay stable for the whole run. They change only on the edge that raises
// `done`.
//
// Ports
//   clk      in   1   rising-edge clock
//   rst      in   1   asynchronous active-high reset
//   start    in   1   request; sampled in IDLE and on the edge leaving DONE
//   a        in  16   multiplicand, sampled on the accepting edge
//   b        in  16   multiplier, sampled on the accepting edge
//   busy     out  1   high in RUN and DONE
//   done     out  1   one-cycle pulse, result valid
//   product  out 16   (a*b)[15:0]
//   prod_hi  out 16   (a*b)[31:16]
//   ovf      out  1   |prod_hi; valid with done, held afterwards
//
// Optional feature
//   ACC_MUL_EARLY_EXIT_EN : when defined, the unit finishes as soon as no set
//   multiplier bits remain. Latency becomes max(1, msb_index(b)+1) cycles.
//   When undefined, latency is always 16 cycles.
// -----------------------------------------------------------------------------
module acc_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [15:0] prod_hi,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] mcand_reg;
    logic [15:0] mplier_reg;
    logic [31:0] acc32_reg;
    logic [4:0]  cnt_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [15:0] product_reg;
    logic [15:0] prod_hi_reg;
    logic        ovf_reg;

    logic [31:0] acc32_next;
    logic [15:0] mplier_next;
    logic        last_step;

    // Partial-product accumulate for the current edge. The sum cannot exceed
    // 32 bits because the full product of two 16-bit values fits in 32 bits.
    assign acc32_next  = acc32_reg + (mplier_reg[0] ? mcand_reg : 32'h0000_0000);
    assign mplier_next = mplier_reg >> 1;

`ifdef ACC_MUL_EARLY_EXIT_EN
    // Finish once the remaining multiplier bits are all zero. The count
    // check is kept as a backstop, although at count 15 the shifted
    // multiplier is always zero anyway.
    assign last_step = (cnt_reg == 5'd15) || (mplier_next == 16'h0000);
`else
    assign last_step = (cnt_reg == 5'd15);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            mcand_reg   <= 32'h0000_0000;
            mplier_reg  <= 16'h0000;
            acc32_reg   <= 32'h0000_0000;
            cnt_reg     <= 5'd0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= 16'h0000;
            prod_hi_reg <= 16'h0000;
            ovf_reg     <= 1'b0;
        end else begin
            case (state_reg)
                // The edge that leaves DONE also samples start. This lets a
                // start held high run back-to-back, one multiply every 17
                // cycles. Starts that arrive during RUN are dropped.
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg  <= RUN;
                        busy_reg   <= 1'b1;
                        mcand_reg  <= {16'h0000, a};
                        mplier_reg <= b;
                        acc32_reg  <= 32'h0000_0000;
                        cnt_reg    <= 5'd0;
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end

                RUN: begin
                    acc32_reg  <= acc32_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_next;
                    cnt_reg    <= cnt_reg + 5'd1;
                    if (last_step) begin
                        state_reg   <= DONE;
                        done_reg    <= 1'b1;
                        product_reg <= acc32_next[15:0];
                        prod_hi_reg <= acc32_next[31:16];
                        ovf_reg     <= |acc32_next[31:16];
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;
    assign prod_hi = prod_hi_reg;
    assign ovf     = ovf_reg;

endmodule

// File: tb/tb_acc_multiplier.sv
// -----------------------------------------------------------------------------
// tb_acc_multiplier
//
// Directed testbench for acc_multiplier. Every expected value below was
// worked out by hand. Expected latencies are given for both builds: the
// fixed 16-cycle build and the ACC_MUL_EARLY_EXIT_EN build. The bench prints
// one line per transaction and ends with a single summary line.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_acc_multiplier;

`ifdef ACC_MUL_EARLY_EXIT_EN
    `define LAT(fixed_lat, early_lat) (early_lat)
`else
    `define LAT(fixed_lat, early_lat) (fixed_lat)
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [15:0] prod_hi;
    logic        ovf;

    int tests_run;
    int tests_failed;

    acc_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .prod_hi (prod_hi),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one multiply: accept on E0, then wait for done within a bounded
    // number of cycles. Checks the latency, the result, and that busy and
    // done drop on the following cycle.
    task automatic do_mult(input string name, input logic [15:0] va, input logic [15:0] vb,
                           input int exp_lat, input logic [15:0] exp_prod,
                           input logic [15:0] exp_hi, input logic exp_ovf);
        int n;
        bit got;
        a = va;
        b = vb;
        start = 1'b1;
        tick();                       // E0: accepted
        start = 1'b0;
        check({name, "_busy_after_accept"}, 32'(busy), 32'd1);
        n = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            tick();
            n++;
            if (done) got = 1'b1;
        end
        check({name, "_latency"}, 32'(n), 32'(exp_lat));
        check({name, "_product"}, 32'(product), 32'(exp_prod));
        check({name, "_prod_hi"}, 32'(prod_hi), 32'(exp_hi));
        check({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        $display("[TB] %s: a=0x%04h b=0x%04h lat=%0d product=0x%04h prod_hi=0x%04h ovf=%0b",
                 name, va, vb, n, product, prod_hi, ovf);
        tick();
        check({name, "_busy_drop"}, 32'(busy), 32'd0);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int done_at;
        int first_done;
        int second_done;
        int lat6;

        tests_run    = 0;
        tests_failed = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;

        // Reset state.
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_prod_hi", 32'(prod_hi), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        // rst together with start: reset wins.
        start = 1'b1;
        a = 16'h0003;
        b = 16'h0003;
        tick();
        check("rst_start_busy", 32'(busy), 32'd0);
        start = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_start_no_accept", 32'(busy), 32'd0);
        $display("[TB] reset: busy=%0b done=%0b product=0x%04h", busy, done, product);

        // Basic multiplies.
        do_mult("mul_3x5", 16'd3, 16'd5, `LAT(16, 3), 16'h000F, 16'h0000, 1'b0);
        do_mult("mul_ffff", 16'hFFFF, 16'hFFFF, `LAT(16, 16), 16'h0001, 16'hFFFE, 1'b1);

        // Results hold while idle.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_product", 32'(product), 32'h0001);
            check("hold_prod_hi", 32'(prod_hi), 32'hFFFE);
            check("hold_ovf", 32'(ovf), 32'd1);
        end
        $display("[TB] hold: product=0x%04h prod_hi=0x%04h ovf=%0b after 20 idle cycles",
                 product, prod_hi, ovf);

        do_mult("mul_b_zero", 16'h1234, 16'h0000, `LAT(16, 1), 16'h0000, 16'h0000, 1'b0);

        // Accept 7*9, then pulse start on edges that land while RUN is active.
        a = 16'd7;
        b = 16'd9;
        start = 1'b1;
        tick();                       // E0
        start = 1'b0;
        done_cnt = 0;
        done_at  = -1;
        for (int k = 1; k <= 24; k++) begin
            a = 16'd2;
            b = 16'd2;
`ifdef ACC_MUL_EARLY_EXIT_EN
            start = (k == 4);
`else
            start = (k == 4) || (k == 16);
`endif
            tick();
            start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        check("ignore_done_count", 32'(done_cnt), 32'd1);
        check("ignore_done_cycle", 32'(done_at), 32'(`LAT(16, 4)));
        check("ignore_product", 32'(product), 32'h003F);
        check("ignore_busy_end", 32'(busy), 32'd0);
        $display("[TB] ignore_start: done_count=%0d done_at=E%0d product=0x%04h",
                 done_cnt, done_at, product);

        // Asynchronous reset during an operation.
        a = 16'd100;
        b = 16'd200;
        start = 1'b1;
        tick();                       // E0
        start = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        check("midrun_product_held", 32'(product), 32'h003F);
        tick();                       // E8
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_product", 32'(product), 32'd0);
        check("async_rst_prod_hi", 32'(prod_hi), 32'd0);
        check("async_rst_ovf", 32'(ovf), 32'd0);
        $display("[TB] async_rst: busy=%0b done=%0b product=0x%04h prod_hi=0x%04h ovf=%0b",
                 busy, done, product, prod_hi, ovf);
        tick();
        rst = 1'b0;
        tick();
        do_mult("mul_100x200", 16'd100, 16'd200, `LAT(16, 8), 16'h4E20, 16'h0000, 1'b0);

        // Start held high continuously: back-to-back acceptances.
        lat6 = `LAT(16, 2);
        a = 16'd2;
        b = 16'd3;
        start = 1'b1;
        first_done  = -1;
        second_done = -1;
        for (int k = 0; k <= 40; k++) begin
            tick();                   // Ek
            if (done) begin
                check("b2b_product", 32'(product), 32'd6);
                if (first_done < 0) begin
                    first_done = k;
                end else begin
                    second_done = k;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_first_done", 32'(first_done), 32'(lat6));
        check("b2b_second_done", 32'(second_done), 32'(2 * lat6 + 1));
        tick();
        check("b2b_done_pulse", 32'(done), 32'd0);
        tick();
        check("b2b_idle", 32'(busy), 32'd0);
        $display("[TB] back_to_back: done at E%0d and E%0d product=0x%04h",
                 first_done, second_done, product);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
